prim_sched: RTL and testbench
=============================

Name: prim_sched

Overview:
- Sequencer for the repeated-digit invalid-ID datapath. Accepts a stream of [lb, ub] ranges.
- Splits each range by decimal digit length L. For each L, enumerates the repetition periods p.
- Issues one job per (L, p) to an external primitive-sum engine over a valid/ready + result handshake.
- Combines the results with Möbius inclusion-exclusion signs and accumulates a grand total, reported after the last range.

Parameters:
- DATA_W, `DATA_WIDTH (64): width of bounds and job bounds.
- SUM_W, `LONG_DATA_WIDTH (128): width of engine results and the accumulator.
- MAX_DIGITS, 20: largest digit length handled; L ranges 1..MAX_DIGITS.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- mode  in  1  0 = exactly-twice (p = L/2 only), 1 = repeated ≥2 times (Möbius over all p). Sampled when a range is accepted.
- range_valid  in  1  range offered.
- range_ready  out  1  high only in IDLE.
- range_lb  in  DATA_W  inclusive lower bound.
- range_ub  in  DATA_W  inclusive upper bound.
- range_last  in  1  final range of the batch.
- job_valid  out  1  job offered to the engine.
- job_ready  in  1  engine accepts the job.
- job_len  out  5  digit length L.
- job_period  out  5  period p.
- job_lo  out  DATA_W  clamped low bound.
- job_hi  out  DATA_W  clamped high bound.
- res_valid  in  1  engine result strobe.
- res_sum  in  SUM_W  unsigned sum of period-p, length-L numbers in [job_lo, job_hi].
- total_valid  out  1  one-cycle pulse when the batch completes.
- total_out  out  SUM_W  batch total; held until the next range is accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: range_ready=1, job_valid=0, total_valid=0, total_out=0, busy=0, accumulator=0, job_* fields=0, FSM=IDLE. Reset at any point, including mid-WAIT, returns to IDLE.
- res_valid is ignored in every state except WAIT. A late result from before a reset is therefore dropped.
- FSM states and transitions:
  - IDLE: a range_valid&&range_ready handshake latches lb, ub, last and mode, then goes to DIGITS. If the previous batch completed, the accumulator is cleared in that same cycle.
  - DIGITS: iterative ×10 powers, one multiply per cycle. Computes dlo=digits(lb) and dhi=digits(ub), with digits(0)=1. If lb>ub, go to FINISH with no jobs. Otherwise set L=dlo and go to CLAMP.
  - CLAMP: lo=max(lb, 10^(L-1)), hi=min(ub, 10^L−1). Set p to the first candidate, then go to PERIOD.
  - PERIOD: scan p ascending, one candidate per cycle. Candidates:
    - mode 0: only p=L/2, and only when L is even.
    - mode 1: all p with p<L, L%p==0 and mu(L/p)≠0.
    - On finding a candidate, latch sign = −mu(L/p) (mode 0: always +) and go to ISSUE.
    - When no candidates remain: if L<dhi, increment L and go to CLAMP; otherwise go to FINISH.
    - L=1 yields no jobs.
  - ISSUE: job_valid=1 with fields stable until job_ready. On the handshake, go to WAIT.
  - WAIT: on res_valid, acc ← acc ± res_sum, then return to PERIOD at the next p.
  - FINISH: if last, pulse total_valid for one cycle, load total_out=acc and mark the batch done. Return to IDLE.
- The mu table is a combinational constant for 1..MAX_DIGITS.
- Arithmetic:
  - acc is signed SUM_W with two's-complement wrap.
  - Intermediate partial sums may be transiently negative. After each range the true contribution is ≥0.
  - total_out is the unsigned reinterpretation of acc.
- At most one job is outstanding. job_valid never drops before job_ready.

Test Plan:
- mode0, range 11–22, last: one job (L=2, p=1, lo=11, hi=22). Engine returns 33. total_valid pulse with total_out=33.
- mode1, range 95–115, last: jobs (2,1,95,99)→99 and (3,1,100,115)→111. total_out=210. Under mode0 the same range issues one job, (2,1,95,99)→99, so total_out=99.
- mode1, range 222220–222229: jobs in order p=1 (sign −), p=2 (+), p=3 (+), each engine result 222222. total_out=222222.
- Backpressure: hold job_ready low for 5 cycles in ISSUE. job_valid and all job_* fields stay constant, and exactly one job is accepted.
- Range with lb=50, ub=40, last: no job_valid, total_valid pulse with total_out=0. A two-range batch (11–22 then 95–115, mode1) gives 33+210=243.
- Reset asserted in WAIT, then res_valid pulsed: no accumulation. Outputs are at reset values and range_ready=1 the next cycle.

Source files
------------

// File: rtl/prim_sched_if.sv
// prim_sched_if: handshake bundle between prim_sched and its host / primitive-sum engine
//   range_*   : range stream in (valid/ready), with mode and last flag
//   job_*     : one (L, p, lo, hi) job out to the engine (valid/ready)
//   res_*     : engine result strobe and unsigned sum
//   total_*   : batch total pulse and held value; busy while not idle
//   master    : host / engine side; slave : prim_sched
interface prim_sched_if #(parameter int DATA_W = 64, parameter int SUM_W = 128);
    logic              mode;
    logic              range_valid;
    logic              range_ready;
    logic [DATA_W-1:0] range_lb;
    logic [DATA_W-1:0] range_ub;
    logic              range_last;
    logic              job_valid;
    logic              job_ready;
    logic [4:0]        job_len;
    logic [4:0]        job_period;
    logic [DATA_W-1:0] job_lo;
    logic [DATA_W-1:0] job_hi;
    logic              res_valid;
    logic [SUM_W-1:0]  res_sum;
    logic              total_valid;
    logic [SUM_W-1:0]  total_out;
    logic              busy;
    modport master (
        output mode, range_valid, range_lb, range_ub, range_last, job_ready, res_valid, res_sum,
        input  range_ready, job_valid, job_len, job_period, job_lo, job_hi, total_valid, total_out, busy
    );
    modport slave (
        input  mode, range_valid, range_lb, range_ub, range_last, job_ready, res_valid, res_sum,
        output range_ready, job_valid, job_len, job_period, job_lo, job_hi, total_valid, total_out, busy
    );
endinterface

// File: rtl/prim_sched.sv
// prim_sched: splits [lb, ub] ranges by digit length, issues one primitive-sum job per
// (L, p) and folds the results with Moebius signs into a batch total
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : range stream in, job/result handshake to the engine, total out, busy
module prim_sched #(
    parameter int DATA_W     = 64,
    parameter int SUM_W      = 128,
    parameter int MAX_DIGITS = 20
) (
    input logic         clock,
    input logic         reset,
    prim_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DIGITS, CLAMP, PERIOD, ISSUE, WAIT, FINISH} state_t;
    // bit n set: mu(n) = +1 (MU_POS) or -1 (MU_NEG); clear in both means mu(n) = 0
    localparam logic [31:0] MU_POS = 32'h0000_C442;
    localparam logic [31:0] MU_NEG = 32'h000A_28AC;
    state_t            state;
    logic [DATA_W-1:0] lb, ub, pw, plo, lo, hi;
    logic [SUM_W-1:0]  acc, total_out;
    logic [4:0]        d, dlo, dhi, len, per, pz, q, r;
    logic              last, mode_r, done, sub, job_valid, total_valid, cand, ge_lo, ge_hi;
    logic [DATA_W+3:0] phi;
    always_comb begin
        pz    = per == 5'd0 ? 5'd1 : per;
        q     = len / pz;
        r     = len % pz;
        cand  = mode_r ? per < len && r == 5'd0 && (MU_POS[q] || MU_NEG[q]) : !len[0] && per == len >> 1;
        ge_lo = lb >= pw;
        ge_hi = ub >= pw;
        // widened so 10^MAX_DIGITS - 1 does not wrap for the top digit length
        phi   = {4'd0, plo} * (DATA_W+4)'(10) - 1'b1;
    end
    // acc wraps in two's complement; partial sums may dip below zero mid-range
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            job_valid   <= 1'b0;
            total_valid <= 1'b0;
            total_out   <= '0;
            acc         <= '0;
            done        <= 1'b0;
            len         <= '0;
            per         <= '0;
            lo          <= '0;
            hi          <= '0;
        end else begin
            total_valid <= 1'b0;
            case (state)
                IDLE: if (bus.range_valid) begin
                    lb     <= bus.range_lb;
                    ub     <= bus.range_ub;
                    last   <= bus.range_last;
                    mode_r <= bus.mode;
                    d      <= 5'd1;
                    pw     <= DATA_W'(10);
                    dlo    <= 5'd1;
                    dhi    <= 5'd1;
                    plo    <= DATA_W'(1);
                    if (done) begin
                        acc  <= '0;
                        done <= 1'b0;
                    end
                    state  <= DIGITS;
                end
                // pw = 10^d; plo tracks 10^(dlo-1) for the first clamp
                DIGITS: begin
                    if (ge_lo) begin
                        dlo <= d + 5'd1;
                        plo <= pw;
                    end
                    if (ge_hi) dhi <= d + 5'd1;
                    if (!(ge_lo || ge_hi) || d == 5'(MAX_DIGITS - 1)) begin
                        len   <= ge_lo ? d + 5'd1 : dlo;
                        state <= lb > ub ? FINISH : CLAMP;
                    end else begin
                        pw <= pw * DATA_W'(10);
                        d  <= d + 5'd1;
                    end
                end
                CLAMP: begin
                    lo    <= lb > plo ? lb : plo;
                    hi    <= {4'd0, ub} < phi ? ub : phi[DATA_W-1:0];
                    per   <= 5'd1;
                    state <= PERIOD;
                end
                PERIOD: if (cand) begin
                    sub       <= mode_r && MU_POS[q];
                    job_valid <= 1'b1;
                    state     <= ISSUE;
                end else if (per + 5'd1 < len) begin
                    per <= per + 5'd1;
                end else if (len < dhi) begin
                    len   <= len + 5'd1;
                    plo   <= plo * DATA_W'(10);
                    state <= CLAMP;
                end else begin
                    state <= FINISH;
                end
                ISSUE: if (bus.job_ready) begin
                    job_valid <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: if (bus.res_valid) begin
                    acc   <= sub ? acc - bus.res_sum : acc + bus.res_sum;
                    per   <= per + 5'd1;
                    state <= PERIOD;
                end
                FINISH: begin
                    if (last) begin
                        total_valid <= 1'b1;
                        total_out   <= acc;
                        done        <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.range_ready = state == IDLE;
    assign bus.busy        = state != IDLE;
    assign bus.job_valid   = job_valid;
    assign bus.job_len     = len;
    assign bus.job_period  = per;
    assign bus.job_lo      = lo;
    assign bus.job_hi      = hi;
    assign bus.total_valid = total_valid;
    assign bus.total_out   = total_out;
endmodule

// File: tb/tb_prim_sched.sv
// tb_prim_sched: randomized and directed check of prim_sched against a brute-force
// invalid-ID sum and an independently enumerated job list
module tb_prim_sched;
    typedef logic [127:0] u128;
    typedef struct {
        int              len;
        int              per;
        longint unsigned lo;
        longint unsigned hi;
    } job_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_jobs = 0;
    job_t exp_q[$];
    u128  batch = 0;
    u128  tot;
    prim_sched_if #(.DATA_W(64), .SUM_W(128)) bus ();
    prim_sched #(.DATA_W(64), .SUM_W(128), .MAX_DIGITS(20)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    always @(posedge clock) if (!reset && bus.job_valid && bus.job_ready) n_jobs++;
    task automatic check(input string tag, input u128 got, input u128 exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask
    function automatic u128 pow10(input int n);
        u128 r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction
    function automatic int ndig(input longint unsigned v);
        int n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction
    function automatic int mu(input int n);
        int r = 1;
        for (int f = 2; f <= n; f++) if (n % f == 0) begin
            n = n / f;
            if (n % f == 0) return 0;
            r = -r;
        end
        return r;
    endfunction
    function automatic bit invalid(input longint unsigned v, input bit m);
        int dg[20];
        int n = 0;
        bit ok;
        do begin
            dg[n] = int'(v % 10);
            v = v / 10;
            n++;
        end while (v != 0);
        for (int p = 1; p < n; p++) begin
            if (n % p != 0 || (!m && 2 * p != n)) continue;
            ok = 1;
            for (int i = p; i < n; i++) if (dg[i] != dg[i - p]) ok = 0;
            if (ok) return 1;
        end
        return 0;
    endfunction
    function automatic u128 brute(input longint unsigned lb, input longint unsigned ub, input bit m);
        u128 s = 0;
        if (lb <= ub) for (longint unsigned v = lb; v <= ub; v++) if (invalid(v, m)) s += u128'(v);
        return s;
    endfunction
    function automatic void gen_jobs(input longint unsigned lb, input longint unsigned ub, input bit m);
        job_t j;
        u128  a, b;
        if (lb > ub) return;
        for (int l = ndig(lb); l <= ndig(ub); l++) begin
            a = pow10(l - 1);
            b = pow10(l) - 1;
            j.len = l;
            j.lo = 64'(u128'(lb) > a ? u128'(lb) : a);
            j.hi = 64'(u128'(ub) < b ? u128'(ub) : b);
            for (int p = 1; p < l; p++)
                if (m ? (l % p == 0 && mu(l / p) != 0) : 2 * p == l) begin
                    j.per = p;
                    exp_q.push_back(j);
                end
        end
    endfunction
    // sum of all x*R in [lo, hi] where x has exactly p digits and R = (10^l-1)/(10^p-1)
    function automatic u128 eng(input int l, input int p, input u128 lo, input u128 hi);
        u128 r, xl, xh;
        r = (pow10(l) - 1) / (pow10(p) - 1);
        xl = (lo + r - 1) / r;
        xh = hi / r;
        if (xl < pow10(p - 1)) xl = pow10(p - 1);
        if (xh > pow10(p) - 1) xh = pow10(p) - 1;
        return xh < xl ? u128'(0) : r * (xl + xh) * (xh - xl + 1) / 2;
    endfunction
    task automatic run_range(input longint unsigned lb, input longint unsigned ub, input bit m,
                             input bit last, input int bp, output u128 t);
        job_t            j;
        int              base, nexp, cyc, sl, sp;
        longint unsigned slo, shi;
        base = n_jobs;
        exp_q.delete();
        gen_jobs(lb, ub, m);
        nexp = exp_q.size();
        batch += brute(lb, ub, m);
        cyc = 0;
        while (!bus.range_ready && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        bus.mode = m;
        bus.range_lb = lb;
        bus.range_ub = ub;
        bus.range_last = last;
        bus.range_valid = 1'b1;
        @(negedge clock);
        bus.range_valid = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 5000) begin
            cyc++;
            if (bus.job_valid) begin
                if (exp_q.size() == 0) check("extra_job", bus.job_valid, 0);
                else begin
                    j = exp_q.pop_front();
                    check("job_len", bus.job_len, j.len);
                    check("job_period", bus.job_period, j.per);
                    check("job_lo", bus.job_lo, j.lo);
                    check("job_hi", bus.job_hi, j.hi);
                end
                sl = int'(bus.job_len);
                sp = int'(bus.job_period);
                slo = bus.job_lo;
                shi = bus.job_hi;
                repeat (bp) begin
                    @(negedge clock);
                    check("bp_valid", bus.job_valid, 1);
                    check("bp_len_per", {bus.job_len, bus.job_period}, {5'(sl), 5'(sp)});
                    check("bp_lo", bus.job_lo, slo);
                    check("bp_hi", bus.job_hi, shi);
                end
                bus.job_ready = 1'b1;
                @(negedge clock);
                bus.job_ready = 1'b0;
                check("job_drop", bus.job_valid, 0);
                repeat ($urandom_range(0, 3)) @(negedge clock);
                bus.res_sum = eng(sl, sp, u128'(slo), u128'(shi));
                bus.res_valid = 1'b1;
                @(negedge clock);
                bus.res_valid = 1'b0;
            end else @(negedge clock);
        end
        check("idle", bus.busy, 0);
        check("total_valid", bus.total_valid, u128'(last));
        check("n_jobs", u128'(n_jobs - base), u128'(nexp));
        if (last) begin
            check("total", bus.total_out, batch);
            batch = 0;
        end
        t = bus.total_out;
        @(negedge clock);
        check("pulse", bus.total_valid, 0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int              cyc, n, k;
        longint unsigned lb, ub, s;
        bit              m, last;
        bus.mode = 1'b0;
        bus.range_valid = 1'b0;
        bus.range_lb = '0;
        bus.range_ub = '0;
        bus.range_last = 1'b0;
        bus.job_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_sum = '0;
        repeat (3) @(negedge clock);
        check("rst_range_ready", bus.range_ready, 1);
        check("rst_job_valid", bus.job_valid, 0);
        check("rst_total_valid", bus.total_valid, 0);
        check("rst_total_out", bus.total_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_job_fields", {bus.job_len, bus.job_period, bus.job_lo, bus.job_hi} == '0, 1);
        reset = 1'b0;
        run_range(11, 22, 0, 1, 0, tot);
        check("t_11_22", tot, 33);
        run_range(95, 115, 1, 1, 0, tot);
        check("t_95_115_m1", tot, 210);
        run_range(95, 115, 0, 1, 0, tot);
        check("t_95_115_m0", tot, 99);
        run_range(222220, 222229, 1, 1, 1, tot);
        check("t_222222", tot, 222222);
        run_range(11, 22, 0, 1, 5, tot);
        check("t_backpressure", tot, 33);
        run_range(50, 40, 0, 1, 0, tot);
        check("t_empty", tot, 0);
        run_range(11, 22, 1, 0, 0, tot);
        run_range(95, 115, 1, 1, 2, tot);
        check("t_batch", tot, 243);
        bus.mode = 1'b0;
        bus.range_lb = 11;
        bus.range_ub = 22;
        bus.range_last = 1'b1;
        bus.range_valid = 1'b1;
        @(negedge clock);
        bus.range_valid = 1'b0;
        cyc = 0;
        while (!bus.job_valid && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check("rst_wait_job", bus.job_valid, 1);
        bus.job_ready = 1'b1;
        @(negedge clock);
        bus.job_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstw_range_ready", bus.range_ready, 1);
        check("rstw_total_out", bus.total_out, 0);
        bus.res_sum = 33;
        bus.res_valid = 1'b1;
        @(negedge clock);
        bus.res_valid = 1'b0;
        check("rstw_busy", bus.busy, 0);
        check("rstw_job_valid", bus.job_valid, 0);
        check("rstw_total_valid", bus.total_valid, 0);
        batch = 0;
        run_range(11, 22, 0, 1, 0, tot);
        check("t_after_reset", tot, 33);
        for (int i = 0; i < 30; i++) begin
            n = $urandom_range(1, 13);
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(1, 600);
                lb = 64'(pow10(n)) > 64'(k) ? 64'(pow10(n)) - 64'(k) : 0;
            end else begin
                lb = 64'(pow10(n - 1)) + {$urandom, $urandom} % 64'(pow10(n) - pow10(n - 1));
            end
            ub = lb + 64'($urandom_range(0, 2500));
            if ($urandom_range(0, 7) == 0) begin
                s = lb;
                lb = ub;
                ub = s;
            end
            m = 1'($urandom_range(0, 1));
            last = i == 29 || $urandom_range(0, 2) == 0;
            run_range(lb, ub, m, last, $urandom_range(0, 2), tot);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
